// File: rtl/pulse2toggle_pkg.sv
// Shared state encoding and default counter width for the pulse-to-toggle transmitter.
package pulse2toggle_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } p2t_state_e;

  localparam int unsigned P2T_CW_DEFAULT = 2;

endpackage

// File: rtl/pulse2toggle_chan.sv
// One pulse-to-toggle channel: flips out per event, queues events while awaiting ack.
// Build option: PULSE2TOGGLE_TX_OVF_EN enables the sticky overflow flag and its clear.
import pulse2toggle_pkg::*;

module pulse2toggle_chan #(
  parameter int unsigned CW = P2T_CW_DEFAULT
) (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  input  logic ack,
  input  logic ovf_clr,
  output logic out,
  output logic busy,
  output logic overflow
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  p2t_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in) begin
          out_d   = ~out_q;
          state_d = WAIT_ACK;
        end else if (cnt_q != '0) begin
          out_d   = ~out_q;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A pulse arriving on the ack-match cycle is still queued, not sent.
        if (in) begin
          if (cnt_q == CNT_MAX) drop = 1'b1;
          else                  cnt_d = cnt_q + CNT_ONE;
        end
        if (ack == out_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == WAIT_ACK) | (cnt_q != '0);

`ifdef PULSE2TOGGLE_TX_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, drop};
  assign overflow   = 1'b0;
`endif

endmodule

// File: rtl/pulse2toggle_tx.sv
// DW independent pulse-to-toggle channels sharing one clock and reset.
// Build option: PULSE2TOGGLE_TX_OVF_EN (see pulse2toggle_chan).
import pulse2toggle_pkg::*;

module pulse2toggle_tx #(
  parameter int unsigned DW = 1,
  parameter int unsigned CW = P2T_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in,
  input  logic [DW-1:0] ack,
  input  logic [DW-1:0] ovf_clr,
  output logic [DW-1:0] out,
  output logic [DW-1:0] busy,
  output logic [DW-1:0] overflow
);

  for (genvar i = 0; i < DW; i++) begin : g_chan
    pulse2toggle_chan #(
      .CW(CW)
    ) u_chan (
      .clk      (clk),
      .nreset   (nreset),
      .in       (in[i]),
      .ack      (ack[i]),
      .ovf_clr  (ovf_clr[i]),
      .out      (out[i]),
      .busy     (busy[i]),
      .overflow (overflow[i])
    );
  end

endmodule

// File: tb/tb_pulse2toggle_tx.sv
// Directed bench for pulse2toggle_tx (DW=4, CW=2); overflow expectations follow PULSE2TOGGLE_TX_OVF_EN.
module tb_pulse2toggle_tx;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 2;
`ifdef PULSE2TOGGLE_TX_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk;
  logic          nreset;
  logic [DW-1:0] in_v, ack_v, clr_v;
  logic [DW-1:0] out_v, busy_v, ovf_v;

  int n_vec = 0;
  int n_err = 0;

  pulse2toggle_tx #(.DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .in       (in_v),
    .ack      (ack_v),
    .ovf_clr  (clr_v),
    .out      (out_v),
    .busy     (busy_v),
    .overflow (ovf_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives pulses on one channel; ack either held or echoes out 'delay' cycles late.
  task automatic run_echo(input int ch, input int delay, input int cycles,
                          input logic [31:0] pulses, input bit hold, output int flips);
    logic [7:0] hist;
    logic       prev;
    flips = 0;
    prev  = out_v[ch];
    hist  = {8{out_v[ch]}};
    for (int c = 0; c < cycles; c++) begin
      in_v[ch] = (c < 32) ? pulses[c] : 1'b0;
      if (!hold) ack_v[ch] = hist[delay-1];
      tick;
      if (out_v[ch] !== prev) flips++;
      prev = out_v[ch];
      hist = {hist[6:0], out_v[ch]};
    end
    in_v[ch] = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    in_v = '0; ack_v = '0; clr_v = '0;
    tick; tick;
    n_vec++; if (out_v !== '0)  begin n_err++; $display("FAIL reset_out got=%b exp=0000", out_v); end
    n_vec++; if (busy_v !== '0) begin n_err++; $display("FAIL reset_busy got=%b exp=0000", busy_v); end
    n_vec++; if (ovf_v !== '0)  begin n_err++; $display("FAIL reset_ovf got=%b exp=0000", ovf_v); end
  endtask

  task automatic test_single;
    nreset  = 1'b1;
    in_v[0] = 1'b1;
    tick;
    in_v[0] = 1'b0;
    n_vec++; if (out_v[0] !== 1'b1)  begin n_err++; $display("FAIL single_out got=%b exp=1", out_v[0]); end
    n_vec++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy_v[0]); end
    tick;
    n_vec++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL single_wait got=%b exp=1", busy_v[0]); end
    ack_v[0] = 1'b1;
    tick;
    n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL single_ack got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_burst;
    int f;
    run_echo(0, 4, 40, 32'b111, 1'b0, f);
    n_vec++; if (f != 3)             begin n_err++; $display("FAIL burst_flips got=%0d exp=3", f); end
    n_vec++; if (ovf_v[0] !== 1'b0)  begin n_err++; $display("FAIL burst_ovf got=%b exp=0", ovf_v[0]); end
    n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL burst_idle got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_saturation;
    int f1, f2;
    run_echo(0, 1, 8, 32'b11111, 1'b1, f1);
    n_vec++; if (f1 != 1)              begin n_err++; $display("FAIL sat_hold_flips got=%0d exp=1", f1); end
    n_vec++; if (ovf_v[0] !== OVF_EXP) begin n_err++; $display("FAIL sat_ovf got=%b exp=%b", ovf_v[0], OVF_EXP); end
    n_vec++; if (busy_v[0] !== 1'b1)   begin n_err++; $display("FAIL sat_busy got=%b exp=1", busy_v[0]); end
    run_echo(0, 1, 30, 32'b0, 1'b0, f2);
    n_vec++; if (f1 + f2 != 4)         begin n_err++; $display("FAIL sat_total_flips got=%0d exp=4", f1 + f2); end
    n_vec++; if (ovf_v[0] !== OVF_EXP) begin n_err++; $display("FAIL sat_ovf_sticky got=%b exp=%b", ovf_v[0], OVF_EXP); end
  endtask

  task automatic test_simultaneous;
    logic v;
    int   f1, f2;
    v = ack_v[0];
    n_vec++; if (out_v[0] !== v) begin n_err++; $display("FAIL simul_start got=%b exp=%b", out_v[0], v); end
    in_v[0] = 1'b1;
    tick;
    in_v[0] = 1'b0;
    tick;
    in_v[0] = 1'b1;
    ack_v[0] = ~v;
    tick;
    in_v[0] = 1'b0;
    n_vec++; if (out_v[0] !== ~v)    begin n_err++; $display("FAIL simul_no_flip got=%b exp=%b", out_v[0], ~v); end
    n_vec++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL simul_pending got=%b exp=1", busy_v[0]); end
    tick;
    n_vec++; if (out_v[0] !== v)     begin n_err++; $display("FAIL simul_flip got=%b exp=%b", out_v[0], v); end
    ack_v[0] = v;
    tick;
    n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL simul_done got=%b exp=0", busy_v[0]); end

    // Overflow set coinciding with clear: set must win, then a lone clear drops it.
    clr_v[0] = 1'b1;
    tick;
    clr_v[0] = 1'b0;
    n_vec++; if (ovf_v[0] !== 1'b0) begin n_err++; $display("FAIL ovf_clear1 got=%b exp=0", ovf_v[0]); end
    run_echo(0, 1, 6, 32'b1111, 1'b1, f1);
    in_v[0] = 1'b1;
    clr_v[0] = 1'b1;
    tick;
    in_v[0] = 1'b0;
    clr_v[0] = 1'b0;
    n_vec++; if (ovf_v[0] !== OVF_EXP) begin n_err++; $display("FAIL ovf_set_wins got=%b exp=%b", ovf_v[0], OVF_EXP); end
    run_echo(0, 1, 30, 32'b0, 1'b0, f2);
    n_vec++; if (f1 + f2 != 4) begin n_err++; $display("FAIL ovf_drain_flips got=%0d exp=4", f1 + f2); end
    clr_v[0] = 1'b1;
    tick;
    clr_v[0] = 1'b0;
    n_vec++; if (ovf_v[0] !== 1'b0) begin n_err++; $display("FAIL ovf_clear2 got=%b exp=0", ovf_v[0]); end
  endtask

  task automatic test_reset_mid;
    int f;
    run_echo(0, 1, 5, 32'b111, 1'b1, f);
    n_vec++; if (out_v[0] !== 1'b1)  begin n_err++; $display("FAIL mid_pre_out got=%b exp=1", out_v[0]); end
    n_vec++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got=%b exp=1", busy_v[0]); end
    #2;
    nreset = 1'b0;
    ack_v  = '0;
    #1;
    n_vec++; if (out_v[0] !== 1'b0)  begin n_err++; $display("FAIL mid_async_out got=%b exp=0", out_v[0]); end
    n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL mid_async_busy got=%b exp=0", busy_v[0]); end
    n_vec++; if (ovf_v[0] !== 1'b0)  begin n_err++; $display("FAIL mid_async_ovf got=%b exp=0", ovf_v[0]); end
    tick;
    nreset = 1'b1;
    run_echo(0, 1, 10, 32'b0, 1'b0, f);
    n_vec++; if (f != 0)             begin n_err++; $display("FAIL mid_no_flips got=%0d exp=0", f); end
    n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL mid_idle got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_independence;
    in_v = 4'b1010;
    tick;
    in_v = '0;
    n_vec++; if (out_v !== 4'b1010)  begin n_err++; $display("FAIL ind_out got=%b exp=1010", out_v); end
    tick;
    ack_v[1] = 1'b1;
    tick;
    n_vec++; if (busy_v !== 4'b1000) begin n_err++; $display("FAIL ind_ch1_done got=%b exp=1000", busy_v); end
    in_v[1] = 1'b1;
    tick;
    in_v[1] = 1'b0;
    n_vec++; if (out_v !== 4'b1000)  begin n_err++; $display("FAIL ind_ch1_again got=%b exp=1000", out_v); end
    ack_v[1] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick;
      n_vec++;
      if ({out_v[2], out_v[0], busy_v[2], busy_v[0]} !== 4'b0000) begin
        n_err++; $display("FAIL ind_static cyc=%0d out=%b busy=%b exp ch0/ch2=0", c, out_v, busy_v);
      end
    end
    n_vec++; if (busy_v !== 4'b1000) begin n_err++; $display("FAIL ind_ch3_wait got=%b exp=1000", busy_v); end
    ack_v[3] = 1'b1;
    tick;
    n_vec++; if (busy_v !== 4'b0000) begin n_err++; $display("FAIL ind_ch3_done got=%b exp=0000", busy_v); end
    n_vec++; if (out_v !== 4'b1000)  begin n_err++; $display("FAIL ind_final_out got=%b exp=1000", out_v); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_saturation;
    test_simultaneous;
    test_reset_mid;
    test_independence;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse2toggle_tx.md
PULSE2TOGGLE_TX -- requirements
Module: pulse2toggle_tx

Interface
REQ-001 SHALL have parameter DW, default 1: number of independent channels.
REQ-002 SHALL have parameter CW, default 2: width of each channel's pending-pulse counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in  input  DW  one-cycle event pulses, one bit per channel.
REQ-006 SHALL have port ack  input  DW  returned toggle from the far side, already synchronized to clk.
REQ-007 SHALL have port ovf_clr  input  DW  per-channel clear of the sticky overflow flag.
REQ-008 SHALL have port out  output  DW  toggle level; each flip represents one event.
REQ-009 SHALL have port busy  output  DW  channel has an unacknowledged toggle or pending events.
REQ-010 SHALL have port overflow  output  DW  sticky per-channel event-loss flag.

Function
REQ-011 Each channel SHALL be independent, with states IDLE and WAIT_ACK and a CW-bit pending counter cnt.
REQ-012 IDLE with in=1: SHALL flip out at the next posedge and go to WAIT_ACK; cnt unchanged.
REQ-013 IDLE with in=0 and cnt>0: SHALL flip out, decrement cnt and go to WAIT_ACK.
REQ-014 IDLE with in=0 and cnt=0: SHALL hold state; out unchanged.
REQ-015 Latency from an in pulse in IDLE with cnt=0 to the out flip SHALL be exactly 1 cycle; out SHALL be a flop output.
REQ-016 WAIT_ACK: when ack==out, SHALL go to IDLE at the next posedge; otherwise stay.
REQ-017 Any in pulse in WAIT_ACK, including the cycle ack matches, SHALL increment cnt.
REQ-018 cnt SHALL saturate at 2^CW-1; a pulse arriving at saturation SHALL be dropped and set overflow at the next posedge.
REQ-019 ack changes while in IDLE (ack!=out in IDLE) SHALL be ignored; no state change.
REQ-020 busy SHALL be combinational: (state==WAIT_ACK) | (cnt!=0).
REQ-021 When overflow set and ovf_clr occur in the same cycle, set SHALL win.
REQ-022 Minimum spacing between successive out flips on one channel SHALL be 2 cycles, plus the ack round trip.

Reset
REQ-023 nreset low SHALL asynchronously force: out=0, state=IDLE, cnt=0, overflow=0, busy=0.
REQ-024 Reset mid-handshake SHALL discard pending events; the far side is reset by the same nreset domain.
REQ-025 The first posedge after nreset deassertion SHALL be able to accept an in pulse.

Configuration
REQ-026 Macro PULSE2TOGGLE_TX_OVF_EN defined: overflow and ovf_clr SHALL behave per REQ-018/REQ-021.
REQ-027 Macro undefined: overflow SHALL be tied 0 and ovf_clr ignored; saturation drop SHALL still occur silently; port list SHALL be unchanged.

Structure
REQ-028 Package pulse2toggle_pkg SHALL hold the state encoding (IDLE=1'b0, WAIT_ACK=1'b1) and the default CW constant.
REQ-029 Per-channel logic SHALL live in sub-module pulse2toggle_chan (CW parameter, 1-bit ports); the top SHALL generate DW instances.

Verification
REQ-030 Reset, single pulse: nreset released, in[0]=1 for 1 cycle -> out[0] 0->1 one cycle later, busy[0]=1; ack[0]=1 two cycles later -> busy[0]=0.
REQ-031 Burst: DW=1, CW=2, 3 pulses in consecutive cycles, ack echoes out after 4 cycles -> exactly 3 out flips, cnt peaks at 2, overflow=0.
REQ-032 Saturation: CW=2, ack held, 5 pulses -> cnt=3, overflow=1 with the macro (0 without), and exactly 4 total flips after ack is resumed.
REQ-033 Simultaneity: pulse in the ack-match cycle -> cnt=1, then one further flip 1 cycle after returning to IDLE. Overflow set and ovf_clr in the same cycle -> overflow stays 1.
REQ-034 Reset mid-operation: nreset asserted in WAIT_ACK with cnt=2 -> out=0, busy=0, overflow=0 immediately (asynchronous), and no flips after release without new pulses.
REQ-035 Independence: DW=4, pulses on ch1 and ch3 only, ch3 ack delayed 10 cycles -> ch1 completes unaffected; ch0/ch2 outputs stay static.
